// File: rtl/regfile_sb_if.sv
// Register-file bus: writeback port, read ports and scoreboard set port.
// The master drives addresses and write/set controls; the slave returns read data and busy flags.
interface regfile_sb_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic                 we;
    logic [AW-1:0]        wa;
    logic [WIDTH-1:0]     wd;
    logic [NRD*AW-1:0]    ra;
    logic [NRD*WIDTH-1:0] rd;
    logic [NRD-1:0]       rd_busy;
    logic                 set_busy;
    logic [AW-1:0]        set_addr;
    logic                 busy_any;

    modport master (
        output we, wa, wd, ra, set_busy, set_addr,
        input  rd, rd_busy, busy_any
    );

    modport slave (
        input  we, wa, wd, ra, set_busy, set_addr,
        output rd, rd_busy, busy_any
    );
endinterface

// File: rtl/regfile_sb.sv
// Multi-read-port register file with a per-register busy scoreboard.
// Register 0 reads as zero and is never busy; reads are combinational with optional write bypass.
module regfile_sb #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 1
) (
    input logic        clk,
    input logic        reset,
    regfile_sb_if.slave bus
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [NREGS-1:0] r_busy;

    logic [WIDTH-1:0] w_rd   [NRD];
    logic [NRD-1:0]   w_busy;

    // Set is applied after the write clear so that a same-cycle set wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (bus.we && (bus.wa != '0)) begin
                r_regs[bus.wa] <= bus.wd;
                r_busy[bus.wa] <= 1'b0;
            end
            if (bus.set_busy && (bus.set_addr != '0)) begin
                r_busy[bus.set_addr] <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_hit;

        assign w_ra  = bus.ra[g*AW +: AW];
        assign w_hit = bus.we && (bus.wa == w_ra);

        always_comb begin
            w_rd[g]   = r_regs[w_ra];
            w_busy[g] = r_busy[w_ra];
            if (reset || (w_ra == '0)) begin
                w_rd[g]   = '0;
                w_busy[g] = 1'b0;
            end else if (w_hit) begin
                // The in-flight write retires the producer regardless of bypass.
                w_busy[g] = 1'b0;
                if (BYPASS != 0) begin
                    w_rd[g] = bus.wd;
                end
            end
        end
    end

    always_comb begin
        bus.rd = '0;
        for (int i = 0; i < NRD; i++) begin
            bus.rd[i*WIDTH +: WIDTH] = w_rd[i];
        end
    end

    assign bus.rd_busy  = w_busy;
    assign bus.busy_any = |r_busy;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector table plus model-checked random traffic for regfile_sb.
// Two instances share stimulus: 4 ports with bypass, 2 ports without bypass.
module tb_regfile_sb;
    logic clk;
    logic reset;

    regfile_sb_if #(.WIDTH(32), .NREGS(32), .NRD(4)) bus_a ();
    regfile_sb_if #(.WIDTH(32), .NREGS(32), .NRD(2)) bus_b ();

    regfile_sb #(.WIDTH(32), .NREGS(32), .NRD(4), .BYPASS(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    regfile_sb #(.WIDTH(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        d_we;
    logic [4:0]  d_wa;
    logic [31:0] d_wd;
    logic [4:0]  d_ra [4];
    logic        d_sb;
    logic [4:0]  d_sa;

    assign bus_a.we       = d_we;
    assign bus_a.wa       = d_wa;
    assign bus_a.wd       = d_wd;
    assign bus_a.ra       = {d_ra[3], d_ra[2], d_ra[1], d_ra[0]};
    assign bus_a.set_busy = d_sb;
    assign bus_a.set_addr = d_sa;
    assign bus_b.we       = d_we;
    assign bus_b.wa       = d_wa;
    assign bus_b.wd       = d_wd;
    assign bus_b.ra       = {d_ra[1], d_ra[0]};
    assign bus_b.set_busy = d_sb;
    assign bus_b.set_addr = d_sa;

    int n_chk;
    int n_fail;

    logic [31:0] m_reg  [32];
    logic        m_busy [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
        if (ra == 5'd0) return 32'd0;
        if (byp && d_we && (d_wa == ra)) return d_wd;
        return m_reg[ra];
    endfunction

    function automatic logic exp_busy(input logic [4:0] ra);
        if (ra == 5'd0) return 1'b0;
        if (d_we && (d_wa == ra)) return 1'b0;
        return m_busy[ra];
    endfunction

    function automatic logic exp_any();
        logic any;
        any = 1'b0;
        for (int i = 0; i < 32; i++) any = any | m_busy[i];
        return any;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'd0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_clock();
        if (d_we && (d_wa != 5'd0)) begin
            m_reg[d_wa]  = d_wd;
            m_busy[d_wa] = 1'b0;
        end
        if (d_sb && (d_sa != 5'd0)) m_busy[d_sa] = 1'b1;
    endtask

    task automatic idle();
        d_we = 1'b0; d_wa = 5'd0; d_wd = 32'd0; d_sb = 1'b0; d_sa = 5'd0;
        for (int i = 0; i < 4; i++) d_ra[i] = 5'd0;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        sb;
        logic [4:0]  sa;
        logic [31:0] rd0_a;
        logic [31:0] rd0_b;
        logic        busy1;
        logic        any;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        idle();
        model_reset();

        //          we  wa     wd            ra0    ra1    sb  sa     rd0_a         rd0_b         b1  any
        vecs[0]  = '{0, 5'd0,  32'h0,        5'd0,  5'd0,  0, 5'd0,  32'h0,        32'h0,        0, 0};
        vecs[1]  = '{1, 5'd7,  32'h1234,     5'd7,  5'd7,  0, 5'd0,  32'h1234,     32'h0,        0, 0};
        vecs[2]  = '{0, 5'd0,  32'h0,        5'd7,  5'd7,  0, 5'd0,  32'h1234,     32'h1234,     0, 0};
        vecs[3]  = '{1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  0, 5'd0,  32'h0,        32'h0,        0, 0};
        vecs[4]  = '{0, 5'd0,  32'h0,        5'd0,  5'd0,  1, 5'd0,  32'h0,        32'h0,        0, 0};
        vecs[5]  = '{0, 5'd0,  32'h0,        5'd7,  5'd3,  1, 5'd3,  32'h1234,     32'h1234,     0, 0};
        vecs[6]  = '{0, 5'd0,  32'h0,        5'd3,  5'd3,  0, 5'd0,  32'h0,        32'h0,        1, 1};
        vecs[7]  = '{1, 5'd3,  32'h33,       5'd3,  5'd3,  0, 5'd0,  32'h33,       32'h0,        0, 1};
        vecs[8]  = '{0, 5'd0,  32'h0,        5'd3,  5'd0,  0, 5'd0,  32'h33,       32'h33,       0, 0};
        vecs[9]  = '{1, 5'd9,  32'hAA,       5'd9,  5'd9,  1, 5'd9,  32'hAA,       32'h0,        0, 0};
        vecs[10] = '{0, 5'd0,  32'h0,        5'd9,  5'd9,  0, 5'd0,  32'hAA,       32'hAA,       1, 1};
        vecs[11] = '{0, 5'd0,  32'h0,        5'd9,  5'd9,  1, 5'd9,  32'hAA,       32'hAA,       1, 1};
        vecs[12] = '{1, 5'd12, 32'h55,       5'd12, 5'd12, 0, 5'd0,  32'h55,       32'h0,        0, 1};
        vecs[13] = '{1, 5'd9,  32'hBB,       5'd9,  5'd12, 0, 5'd0,  32'hBB,       32'hAA,       0, 1};
        vecs[14] = '{0, 5'd0,  32'h0,        5'd9,  5'd12, 0, 5'd0,  32'hBB,       32'hBB,       0, 0};
        vecs[15] = '{1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  0, 5'd0,  32'hDEADBEEF, 32'h0,        0, 0};
        vecs[16] = '{0, 5'd0,  32'h0,        5'd5,  5'd5,  1, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
        vecs[17] = '{0, 5'd0,  32'h0,        5'd5,  5'd5,  0, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1, 1};

        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rd0_a", bus_a.rd[31:0], 32'd0);
        chk("reset_busy_any_a", {31'd0, bus_a.busy_any}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed table; port 2/3 of the 4-port instance mirror port 0.
        for (int v = 0; v < NVEC; v++) begin
            d_we = vecs[v].we; d_wa = vecs[v].wa; d_wd = vecs[v].wd;
            d_sb = vecs[v].sb; d_sa = vecs[v].sa;
            d_ra[0] = vecs[v].ra0; d_ra[1] = vecs[v].ra1;
            d_ra[2] = vecs[v].ra0; d_ra[3] = vecs[v].ra0;
            #2;
            chk($sformatf("v%0d_rd0_a", v), bus_a.rd[31:0], vecs[v].rd0_a);
            chk($sformatf("v%0d_rd2_a", v), bus_a.rd[95:64], vecs[v].rd0_a);
            chk($sformatf("v%0d_rd3_a", v), bus_a.rd[127:96], vecs[v].rd0_a);
            chk($sformatf("v%0d_rd0_b", v), bus_b.rd[31:0], vecs[v].rd0_b);
            chk($sformatf("v%0d_busy1_a", v), {31'd0, bus_a.rd_busy[1]}, {31'd0, vecs[v].busy1});
            chk($sformatf("v%0d_busy1_b", v), {31'd0, bus_b.rd_busy[1]}, {31'd0, vecs[v].busy1});
            chk($sformatf("v%0d_any_a", v), {31'd0, bus_a.busy_any}, {31'd0, vecs[v].any});
            chk($sformatf("v%0d_any_b", v), {31'd0, bus_b.busy_any}, {31'd0, vecs[v].any});
            @(posedge clk);
            model_clock();
            @(negedge clk);
        end

        // Mid-run asynchronous reset: r5 holds DEADBEEF and is busy; outputs clear before any edge.
        idle();
        d_ra[0] = 5'd5; d_ra[1] = 5'd5; d_ra[2] = 5'd7; d_ra[3] = 5'd12;
        #1;
        chk("pre_reset_rd0", bus_a.rd[31:0], 32'hDEADBEEF);
        reset = 1'b1;
        #1;
        chk("async_reset_rd0_a", bus_a.rd[31:0], 32'd0);
        chk("async_reset_rd3_a", bus_a.rd[127:96], 32'd0);
        chk("async_reset_rd0_b", bus_b.rd[31:0], 32'd0);
        chk("async_reset_busy_a", {28'd0, bus_a.rd_busy}, 32'd0);
        chk("async_reset_any_a", {31'd0, bus_a.busy_any}, 32'd0);
        chk("async_reset_any_b", {31'd0, bus_b.busy_any}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_rd0_a", bus_a.rd[31:0], 32'd0);
        chk("post_reset_rd1_b", bus_b.rd[63:32], 32'd0);
        @(negedge clk);

        // Random traffic against the reference model; small address pool raises collisions.
        for (int c = 0; c < 3000; c++) begin
            d_we = 1'($urandom_range(0, 1));
            d_wa = 5'($urandom_range(0, 15));
            d_wd = $urandom;
            d_sb = 1'($urandom_range(0, 1));
            d_sa = 5'($urandom_range(0, 15));
            for (int p = 0; p < 4; p++) d_ra[p] = 5'($urandom_range(0, 15));
            #2;
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("rnd%0d_rd%0d_a", c, p), bus_a.rd[p*32 +: 32], exp_rd(d_ra[p], 1'b1));
                chk($sformatf("rnd%0d_busy%0d_a", c, p), {31'd0, bus_a.rd_busy[p]},
                    {31'd0, exp_busy(d_ra[p])});
            end
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("rnd%0d_rd%0d_b", c, p), bus_b.rd[p*32 +: 32], exp_rd(d_ra[p], 1'b0));
                chk($sformatf("rnd%0d_busy%0d_b", c, p), {31'd0, bus_b.rd_busy[p]},
                    {31'd0, exp_busy(d_ra[p])});
            end
            chk($sformatf("rnd%0d_any_a", c), {31'd0, bus_a.busy_any}, {31'd0, exp_any()});
            chk($sformatf("rnd%0d_any_b", c), {31'd0, bus_b.busy_any}, {31'd0, exp_any()});
            @(posedge clk);
            model_clock();
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
